// File: rtl/hazard_scoreboard.sv
// Producer-side hazard scoreboard for the 5-stage pipeline: tracks when each in-flight
// destination becomes forwardable and stalls ID on RAW, WAW and multiplier conflicts.
module hazard_scoreboard #(
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 4,
  parameter int CNT_W    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_is_load,
  input  logic        id_is_mul,
  input  logic        ex_flush,
  output logic        stall,
  output logic        bubble,
  output logic        mul_busy,
  output logic [31:0] stall_count
);

  localparam logic [CNT_W-1:0] LOAD_L = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] MUL_L  = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] cnt [32];
  logic [CNT_W-1:0] eff [32];
  logic [CNT_W-1:0] mul_cnt;
  logic [CNT_W-1:0] mul_eff;
  logic [CNT_W-1:0] lat;
  logic [4:0]       last_rd;
  logic             last_set;
  logic             last_mul;
  logic             mul_issue;
  logic             issue;

  always_comb begin
    lat = '0;
    if (id_is_load)
      lat = LOAD_L;
    else if (id_is_mul)
      lat = MUL_L;
  end

  // A flush of last cycle's instruction hides its entry immediately, so the
  // instruction now in ID does not stall on a result that will never arrive.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      eff[r] = cnt[r];
      if (r == 0 || (ex_flush && last_set && last_rd == 5'(r)))
        eff[r] = '0;
    end
    mul_eff = (ex_flush && last_mul) ? '0 : mul_cnt;
  end

  always_comb begin
    stall = 1'b0;
    if (id_valid) begin
      if (id_use_rs1 && eff[id_rs1] != '0)
        stall = 1'b1;
      if (id_use_rs2 && eff[id_rs2] != '0)
        stall = 1'b1;
      if (id_regwrite && id_rd != 5'd0 && eff[id_rd] > lat)
        stall = 1'b1;
      if (id_is_mul && mul_eff != '0)
        stall = 1'b1;
    end
  end

  assign bubble    = stall;
  assign issue     = id_valid && !stall;
  assign mul_issue = issue && id_is_mul && !id_is_load;
  assign mul_busy  = (mul_cnt != '0);

  // Issue reloads the counter; otherwise the (flush-masked) count ticks down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++)
        cnt[r] <= '0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        if (r != 0 && issue && id_regwrite && id_rd == 5'(r))
          cnt[r] <= lat;
        else if (eff[r] != '0)
          cnt[r] <= eff[r] - ONE;
        else
          cnt[r] <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_cnt  <= '0;
      last_rd  <= '0;
      last_set <= 1'b0;
      last_mul <= 1'b0;
    end else begin
      if (mul_issue)
        mul_cnt <= MUL_L;
      else if (mul_eff != '0)
        mul_cnt <= mul_eff - ONE;
      else
        mul_cnt <= '0;
      last_rd  <= id_rd;
      last_set <= issue && id_regwrite && id_rd != 5'd0 && lat != '0;
      last_mul <= mul_issue;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (stall && stall_count != 32'hFFFF_FFFF)
      stall_count <= stall_count + 32'd1;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random traffic, all
// checked against an absolute-time model of when each register result becomes ready.
module tb_hazard_scoreboard;

  localparam int LOAD_LAT = 1;
  localparam int MUL_LAT  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_is_load, id_is_mul, ex_flush;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        stall, bubble, mul_busy;
  logic [31:0] stall_count;

  int total = 0;
  int bad   = 0;

  // Model: ready[r] is the cycle at which register r's result is forwardable.
  int          ready [32];
  int          mul_free;
  int          last_cycle, last_rd_m, last_mul_cycle;
  int          now = 0;
  int unsigned exp_cnt;

  hazard_scoreboard #(.LOAD_LAT(LOAD_LAT), .MUL_LAT(MUL_LAT), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_is_mul(id_is_mul),
    .ex_flush(ex_flush), .stall(stall), .bubble(bubble), .mul_busy(mul_busy),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic int lat_m();
    if (id_is_load) return LOAD_LAT;
    if (id_is_mul) return MUL_LAT;
    return 0;
  endfunction

  function automatic int rem(int r);
    if (r == 0) return 0;
    if (ex_flush && last_cycle == now - 1 && last_rd_m == r) return 0;
    return (ready[r] > now) ? ready[r] - now : 0;
  endfunction

  function automatic int mul_rem();
    if (ex_flush && last_mul_cycle == now - 1) return 0;
    return (mul_free > now) ? mul_free - now : 0;
  endfunction

  function automatic logic model_stall();
    if (!id_valid) return 1'b0;
    if (id_use_rs1 && rem(int'(id_rs1)) > 0) return 1'b1;
    if (id_use_rs2 && rem(int'(id_rs2)) > 0) return 1'b1;
    if (id_regwrite && id_rd != 5'd0 && rem(int'(id_rd)) > lat_m()) return 1'b1;
    if (id_is_mul && mul_rem() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) ready[r] = 0;
    mul_free       = 0;
    last_cycle     = -10;
    last_mul_cycle = -10;
    last_rd_m      = 0;
    exp_cnt        = 0;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                               input logic rw, input logic ld, input logic mul, input logic fl);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_is_load = ld; id_is_mul = mul; ex_flush = fl;
  endtask

  // Commits the current ID inputs into the model, then crosses one rising edge.
  task automatic advance();
    logic s;
    int   l;
    logic iss;
    s   = model_stall();
    l   = lat_m();
    iss = id_valid && !s;
    if (s) exp_cnt++;
    if (ex_flush && last_cycle == now - 1) ready[last_rd_m] = now;
    if (ex_flush && last_mul_cycle == now - 1) mul_free = now;
    if (iss && id_regwrite && id_rd != 5'd0) ready[id_rd] = now + 1 + l;
    if (iss && id_is_mul && !id_is_load) mul_free = now + 1 + MUL_LAT;
    last_cycle     = (iss && id_regwrite && id_rd != 5'd0 && l != 0) ? now : -10;
    last_rd_m      = int'(id_rd);
    last_mul_cycle = (iss && id_is_mul && !id_is_load) ? now : -10;
    @(posedge clk);
    now++;
    #1;
  endtask

  task automatic hold_until_issue(output int n);
    logic was;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      was = stall;
      if (was) n++;
      advance();
      if (!was) return;
    end
    n = 99;
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      advance();
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) applyStimulus(1, 1, 0, 2, 0, 5, 1, 1, 0, 0);
      else            applyStimulus(1, 5, 1, 5, 1, 6, 1, 0, 0, 0);
      @(negedge clk);
      total++;
      if (stall !== 1'b0 || bubble !== 1'b0 || mul_busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_hold: stall=%b bubble=%b mul_busy=%b expected 0 0 0", stall, bubble, mul_busy);
      end
      @(posedge clk); now++; #1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++;
    if (stall_count !== 32'd0 || stall !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release: stall_count=%0d stall=%b expected 0 0", stall_count, stall);
    end
    advance();
    applyStimulus(1, 1, 0, 2, 0, 5, 1, 1, 0, 0);
    hold_until_issue(n);
    applyStimulus(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    @(negedge clk);
    total++;
    if (stall !== model_stall() || stall !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_pre_stall: stall=%b expected 1", stall);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (stall !== 1'b0 || bubble !== 1'b0 || stall_count !== 32'd0) begin
      bad++;
      $display("[TB] FAIL reset_mid_stall: stall=%b bubble=%b count=%0d expected 0 0 0", stall, bubble, stall_count);
    end
    @(posedge clk); now++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle_cycles(2);
  endtask

  task automatic test_load_use();
    int n;
    applyStimulus(1, 1, 0, 2, 0, 5, 1, 1, 0, 0);
    hold_until_issue(n);
    applyStimulus(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    hold_until_issue(n);
    total++;
    if (n !== LOAD_LAT) begin
      bad++;
      $display("[TB] FAIL load_use_stalls: got %0d expected %0d", n, LOAD_LAT);
    end
    total++;
    if (stall_count !== 32'd1 || stall_count !== exp_cnt) begin
      bad++;
      $display("[TB] FAIL load_use_count: got %0d expected 1", stall_count);
    end
    applyStimulus(1, 1, 0, 2, 0, 5, 1, 1, 0, 0);
    hold_until_issue(n);
    applyStimulus(1, 3, 1, 4, 1, 2, 1, 0, 0, 0);
    hold_until_issue(n);
    applyStimulus(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    hold_until_issue(n);
    total++;
    if (n !== 0) begin
      bad++;
      $display("[TB] FAIL load_use_spaced: got %0d expected 0", n);
    end
  endtask

  task automatic test_mul_chain();
    int n;
    applyStimulus(1, 1, 1, 2, 1, 7, 1, 0, 1, 0);
    hold_until_issue(n);
    total++;
    if (mul_busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mul_busy_set: got %b expected 1", mul_busy);
    end
    applyStimulus(1, 7, 1, 7, 1, 8, 1, 0, 0, 0);
    hold_until_issue(n);
    total++;
    if (n !== MUL_LAT) begin
      bad++;
      $display("[TB] FAIL mul_dep_stalls: got %0d expected %0d", n, MUL_LAT);
    end
    idle_cycles(6);
    applyStimulus(1, 1, 1, 2, 1, 7, 1, 0, 1, 0);
    hold_until_issue(n);
    applyStimulus(1, 1, 1, 2, 1, 11, 1, 0, 1, 0);
    hold_until_issue(n);
    total++;
    if (n !== MUL_LAT) begin
      bad++;
      $display("[TB] FAIL mul_back_to_back: got %0d expected %0d", n, MUL_LAT);
    end
    idle_cycles(6);
  endtask

  task automatic test_waw();
    int n;
    applyStimulus(1, 1, 1, 2, 1, 9, 1, 0, 1, 0);
    hold_until_issue(n);
    applyStimulus(1, 1, 1, 0, 0, 9, 1, 0, 0, 0);
    hold_until_issue(n);
    total++;
    if (n !== MUL_LAT) begin
      bad++;
      $display("[TB] FAIL waw_mul_alu: got %0d expected %0d", n, MUL_LAT);
    end
    idle_cycles(6);
    applyStimulus(1, 1, 0, 0, 0, 9, 1, 1, 0, 0);
    hold_until_issue(n);
    applyStimulus(1, 1, 1, 0, 0, 9, 1, 0, 0, 0);
    hold_until_issue(n);
    total++;
    if (n !== LOAD_LAT) begin
      bad++;
      $display("[TB] FAIL waw_load_alu: got %0d expected %0d", n, LOAD_LAT);
    end
    applyStimulus(1, 1, 0, 0, 0, 9, 1, 1, 0, 0);
    hold_until_issue(n);
    applyStimulus(1, 1, 0, 0, 0, 9, 1, 1, 0, 0);
    hold_until_issue(n);
    total++;
    if (n !== 0) begin
      bad++;
      $display("[TB] FAIL waw_load_load: got %0d expected 0", n);
    end
    idle_cycles(2);
  endtask

  task automatic test_flush();
    int n;
    applyStimulus(1, 1, 0, 2, 0, 10, 1, 1, 0, 0);
    hold_until_issue(n);
    applyStimulus(1, 10, 1, 0, 0, 11, 1, 0, 0, 1);
    @(negedge clk);
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("[TB] FAIL flush_no_stall: stall=%b expected 0", stall);
    end
    advance();
    applyStimulus(1, 10, 1, 10, 1, 12, 1, 0, 0, 0);
    @(negedge clk);
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("[TB] FAIL flush_cleared: stall=%b expected 0", stall);
    end
    advance();
    applyStimulus(1, 1, 0, 2, 0, 10, 1, 1, 0, 0);
    hold_until_issue(n);
    applyStimulus(1, 1, 0, 0, 0, 10, 1, 1, 0, 1);
    hold_until_issue(n);
    applyStimulus(1, 10, 1, 0, 0, 12, 1, 0, 0, 0);
    hold_until_issue(n);
    total++;
    if (n !== LOAD_LAT) begin
      bad++;
      $display("[TB] FAIL flush_younger_wins: got %0d expected %0d", n, LOAD_LAT);
    end
    applyStimulus(1, 1, 1, 2, 1, 13, 1, 0, 1, 0);
    hold_until_issue(n);
    applyStimulus(1, 3, 1, 4, 1, 14, 1, 0, 1, 1);
    @(negedge clk);
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("[TB] FAIL flush_mul: stall=%b expected 0", stall);
    end
    advance();
    idle_cycles(6);
  endtask

  task automatic test_x0_invalid();
    int n;
    applyStimulus(1, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    hold_until_issue(n);
    applyStimulus(1, 0, 1, 0, 1, 1, 1, 0, 0, 0);
    hold_until_issue(n);
    total++;
    if (n !== 0) begin
      bad++;
      $display("[TB] FAIL x0_load: got %0d expected 0", n);
    end
    applyStimulus(1, 1, 0, 0, 0, 5, 1, 1, 0, 0);
    hold_until_issue(n);
    applyStimulus(0, 5, 1, 5, 1, 6, 1, 0, 0, 0);
    @(negedge clk);
    total++;
    if (stall !== 1'b0 || bubble !== 1'b0) begin
      bad++;
      $display("[TB] FAIL invalid_no_stall: stall=%b bubble=%b expected 0 0", stall, bubble);
    end
    advance();
    applyStimulus(1, 5, 1, 5, 1, 6, 1, 0, 0, 0);
    hold_until_issue(n);
    total++;
    if (n !== 0) begin
      bad++;
      $display("[TB] FAIL invalid_decrement: got %0d expected 0", n);
    end
  endtask

  task automatic test_random();
    int k;
    logic es;
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 3);
      applyStimulus(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 5)),
                    1'($urandom_range(0, 1)), (k == 0), (k == 1), ($urandom_range(0, 5) == 0));
      @(negedge clk);
      es = model_stall();
      total++;
      if (stall !== es) begin
        bad++;
        $display("[TB] FAIL rand_stall: cycle %0d got %b expected %b", now, stall, es);
      end
      total++;
      if (bubble !== es) begin
        bad++;
        $display("[TB] FAIL rand_bubble: cycle %0d got %b expected %b", now, bubble, es);
      end
      total++;
      if (mul_busy !== (mul_free > now)) begin
        bad++;
        $display("[TB] FAIL rand_mul_busy: cycle %0d got %b expected %b", now, mul_busy, (mul_free > now));
      end
      total++;
      if (stall_count !== exp_cnt) begin
        bad++;
        $display("[TB] FAIL rand_count: cycle %0d got %0d expected %0d", now, stall_count, exp_cnt);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mul_chain();
    test_waw();
    test_flush();
    test_x0_invalid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
